cinf_slave_mem_model: RTL and testbench

//  Responder (slave) end of common_interface: accepts cmd/wr/rd handshakes from an initiator and

---
 rtl/cinf_pkg.sv | 34 +++
 rtl/cinf_sp_ram.sv | 29 ++
 rtl/cinf_slave_mem_model.sv | 183 ++++++++++++++++++
 tb/tb_cinf_slave_mem_model.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cinf_pkg.sv
// Shared definitions for the common_interface responder and its command drivers.
//   cmd_t    : command encoding on the cmd port
//   state_t  : responder FSM states
//   is_wr_cmd / is_rd_cmd : command class decode
package cinf_pkg;

  typedef enum logic [3:0] {
    CmdIdle       = 4'd0,
    CmdCompleteWr = 4'd1,
    CmdWrWnoStop  = 4'd2,
    CmdCompleteRd = 4'd3,
    CmdRdWnoStop  = 4'd4,
    CmdSetIdle    = 4'd5
  } cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StChk,
    StWr,
    StRdLat,
    StRd,
    StFin
  } state_t;

  // A repeated start keeps the pointer, so the STOP and no-STOP variants decode alike.
  function automatic logic is_wr_cmd(cmd_t c);
    return (c == CmdCompleteWr) || (c == CmdWrWnoStop);
  endfunction

  function automatic logic is_rd_cmd(cmd_t c);
    return (c == CmdCompleteRd) || (c == CmdRdWnoStop);
  endfunction

endpackage

// File: rtl/cinf_sp_ram.sv
// Single-port synchronous RAM, DEPTH x 8, one-cycle read latency, write-first.
//   clk_i    : clock
//   we_i     : write enable
//   addr_i   : read/write address
//   wdata_i  : write byte
//   rdata_o  : byte at addr_i one cycle later (the written byte on a write)
module cinf_sp_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_o       <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/cinf_slave_mem_model.sv
// Responder end of common_interface emulating an EEPROM-style I2C memory target.
//   clock, rst                    : clock, asynchronous active-high reset
//   cmd_vld/cmd_ready/cmd/addr/burst_len : command handshake and transaction attributes
//   wr_data/wr_vld/wr_ready/wr_last      : write byte stream (beat 0 is the byte pointer)
//   rd_data/rd_vld/rd_ready/rd_last      : read byte stream
//   nack, done                    : one-cycle status pulses
// The pointer is loaded from a single byte, so MEM_DEPTH must not exceed 256.
module cinf_slave_mem_model
  import cinf_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = 7'h50,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned BURST_W   = 8
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               cmd_vld,
  output logic               cmd_ready,
  input  logic [3:0]         cmd,
  input  logic [6:0]         addr,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [7:0]         wr_data,
  input  logic               wr_vld,
  output logic               wr_ready,
  input  logic               wr_last,
  output logic [7:0]         rd_data,
  output logic               rd_vld,
  input  logic               rd_ready,
  output logic               rd_last,
  output logic               nack,
  output logic               done
);

  localparam int unsigned PTR_W = $clog2(MEM_DEPTH);

  state_t             state_q;
  cmd_t               cmd_q;
  logic [6:0]         addr_q;
  logic [BURST_W-1:0] len_q;
  logic [BURST_W-1:0] beat_q;
  logic [PTR_W-1:0]   ptr_q;
  logic               cmd_ready_q;
  logic               wr_ready_q;
  logic               rd_vld_q;
  logic               rd_last_q;
  logic [7:0]         rd_data_q;
  logic               nack_q;
  logic               done_q;

  logic [BURST_W:0]   beat_inc;
  logic               len_reached;
  logic               ram_we;
  logic [PTR_W-1:0]   ram_addr;
  logic [7:0]         ram_rdata;

  // Extra bit so a count equal to the maximum burst_len compares correctly.
  assign beat_inc    = {1'b0, beat_q} + (BURST_W + 1)'(1);
  assign len_reached = (beat_inc == {1'b0, len_q});

  always_comb begin
    ram_addr = ptr_q;
    ram_we   = 1'b0;
    // Prefetch the next byte on a read handshake so it is ready when StRdLat loads it.
    if (state_q == StRd && rd_vld_q && rd_ready) begin
      ram_addr = ptr_q + PTR_W'(1);
    end
    if (state_q == StWr && wr_vld && wr_ready_q && beat_q != '0) begin
      ram_we = 1'b1;
    end
  end

  cinf_sp_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wr_data),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_q       <= CmdIdle;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      ptr_q       <= '0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      nack_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      nack_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_vld && cmd_ready_q) begin
            cmd_q       <= cmd_t'(cmd);
            addr_q      <= addr;
            len_q       <= (burst_len == '0) ? BURST_W'(1) : burst_len;
            cmd_ready_q <= 1'b0;
            state_q     <= StChk;
          end
        end
        StChk: begin
          beat_q <= '0;
          if (addr_q != DEV_ADDR) begin
            nack_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StFin;
          end else if (is_wr_cmd(cmd_q)) begin
            wr_ready_q <= 1'b1;
            state_q    <= StWr;
          end else if (is_rd_cmd(cmd_q)) begin
            // RAM read at ptr is issued this cycle via the default ram_addr.
            wr_ready_q <= 1'b1;
            state_q    <= StRdLat;
          end else begin
            done_q  <= 1'b1;
            state_q <= StFin;
          end
        end
        StWr: begin
          if (wr_vld) begin
            if (beat_q == '0) begin
              ptr_q <= wr_data[PTR_W-1:0];
            end else begin
              ptr_q <= ptr_q + PTR_W'(1);
            end
            beat_q <= beat_inc[BURST_W-1:0];
            if (wr_last || len_reached) begin
              wr_ready_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StFin;
            end
          end
        end
        StRdLat: begin
          rd_data_q <= ram_rdata;
          rd_vld_q  <= 1'b1;
          rd_last_q <= len_reached;
          state_q   <= StRd;
        end
        StRd: begin
          // Write beats arriving here are accepted and dropped.
          if (rd_ready) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            ptr_q     <= ptr_q + PTR_W'(1);
            beat_q    <= beat_inc[BURST_W-1:0];
            if (rd_last_q) begin
              wr_ready_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StFin;
            end else begin
              state_q <= StRdLat;
            end
          end
        end
        StFin: begin
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_vld    = rd_vld_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = rd_data_q;
  assign nack      = nack_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cinf_slave_mem_model.sv
module tb_cinf_slave_mem_model;
  import cinf_pkg::*;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_vld = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd = 4'd0;
  logic [6:0] addr = 7'd0;
  logic [7:0] burst_len = 8'd0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_vld = 1'b0;
  logic       wr_ready;
  logic       wr_last = 1'b0;
  logic [7:0] rd_data;
  logic       rd_vld;
  logic       rd_ready = 1'b1;
  logic       rd_last;
  logic       nack;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cinf_slave_mem_model #(
    .DEV_ADDR  (7'h50),
    .MEM_DEPTH (256),
    .BURST_W   (8)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .cmd_vld   (cmd_vld),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .addr      (addr),
    .burst_len (burst_len),
    .wr_data   (wr_data),
    .wr_vld    (wr_vld),
    .wr_ready  (wr_ready),
    .wr_last   (wr_last),
    .rd_data   (rd_data),
    .rd_vld    (rd_vld),
    .rd_ready  (rd_ready),
    .rd_last   (rd_last),
    .nack      (nack),
    .done      (done)
  );

  // One transaction: byte i of wr/rd lives at bits [8*i +: 8].
  typedef struct packed {
    cmd_t        cmd;
    logic [6:0]  addr;
    logic [7:0]  len;
    int          nwr;
    logic [47:0] wr;
    logic        use_last;
    logic        stall;
    int          nrd;
    logic [31:0] rd;
    int          exp_wr;
    logic        exp_nack;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_rd_vld"}, 32'(rd_vld), 32'd0);
    chk({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_nack"}, 32'(nack), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic run_txn(input int i);
    vec_t       v;
    int         wi, ri, rv_cnt, wacc, k;
    bit         got_done, got_nack, saw_rd, saw_wr, hold_pend, wr_hs;
    logic [7:0] hd;
    logic       hl;
    logic [3:0] pat;
    v = tv[i];
    pat = 4'b1001;  // rd_ready sequence 1,0,0,1 (bit 0 first)
    cmd_vld = 1'b1;
    cmd = v.cmd;
    addr = v.addr;
    burst_len = v.len;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    chk($sformatf("t%0d_cmd_ready", i), 32'(cmd_ready), 32'd1);
    @(posedge clock); #1;
    cmd_vld = 1'b0;
    wi = 0; ri = 0; rv_cnt = 0; wacc = 0;
    got_done = 0; got_nack = 0; saw_rd = 0; saw_wr = 0; hold_pend = 0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      wr_vld = (wi < v.nwr);
      wr_data = (wi < v.nwr) ? v.wr[8*wi +: 8] : 8'd0;
      wr_last = v.use_last && (wi == v.nwr - 1);
      rd_ready = v.stall ? pat[rv_cnt % 4] : 1'b1;
      if (hold_pend) begin
        chk($sformatf("t%0d_hold_vld", i), 32'(rd_vld), 32'd1);
        chk($sformatf("t%0d_hold_data", i), 32'(rd_data), 32'(hd));
        chk($sformatf("t%0d_hold_last", i), 32'(rd_last), 32'(hl));
        hold_pend = 0;
      end
      if (rd_vld) begin
        saw_rd = 1;
        rv_cnt++;
        if (rd_ready) begin
          if (ri < 4) begin
            chk($sformatf("t%0d_rd_data%0d", i, ri), 32'(rd_data), 32'(v.rd[8*ri +: 8]));
            chk($sformatf("t%0d_rd_last%0d", i, ri), 32'(rd_last), 32'(ri == v.nrd - 1));
          end else begin
            chk($sformatf("t%0d_extra_beat", i), 32'(ri), 32'(v.nrd));
          end
          ri++;
        end else begin
          hold_pend = 1;
          hd = rd_data;
          hl = rd_last;
        end
      end
      if (wr_ready) saw_wr = 1;
      wr_hs = wr_vld && wr_ready;
      if (wr_hs) wacc++;
      if (nack) got_nack = 1;
      if (done) got_done = 1;
      @(posedge clock); #1;
      if (wr_hs) wi++;
    end
    wr_vld = 1'b0;
    wr_last = 1'b0;
    rd_ready = 1'b1;
    chk($sformatf("t%0d_done", i), 32'(got_done), 32'd1);
    chk($sformatf("t%0d_nack", i), 32'(got_nack), 32'(v.exp_nack));
    chk($sformatf("t%0d_wr_beats", i), 32'(wacc), 32'(v.exp_wr));
    chk($sformatf("t%0d_rd_beats", i), 32'(ri), 32'(v.nrd));
    chk($sformatf("t%0d_saw_rd_vld", i), 32'(saw_rd), 32'(v.nrd > 0));
    chk($sformatf("t%0d_saw_wr_ready", i), 32'(saw_wr), 32'(v.exp_wr > 0 || v.nrd > 0));
    // Sampled in the FIN cycle; one edge later the model is idle again.
    chk($sformatf("t%0d_done_pulse", i), 32'(done), 32'd0);
    chk($sformatf("t%0d_idle_ready", i), 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    tv[0]  = '{cmd: CmdCompleteWr, addr: 7'h50, len: 8'd4, nwr: 4, wr: 48'h0000_A3A2A110,
               use_last: 1'b1, stall: 1'b0, nrd: 0, rd: 32'h0, exp_wr: 4, exp_nack: 1'b0};
    tv[1]  = '{cmd: CmdCompleteWr, addr: 7'h50, len: 8'd1, nwr: 1, wr: 48'h10,
               use_last: 1'b0, stall: 1'b0, nrd: 0, rd: 32'h0, exp_wr: 1, exp_nack: 1'b0};
    tv[2]  = '{cmd: CmdCompleteRd, addr: 7'h50, len: 8'd3, nwr: 0, wr: 48'h0,
               use_last: 1'b0, stall: 1'b0, nrd: 3, rd: 32'h00A3A2A1, exp_wr: 0, exp_nack: 1'b0};
    tv[3]  = '{cmd: CmdCompleteRd, addr: 7'h51, len: 8'd3, nwr: 0, wr: 48'h0,
               use_last: 1'b0, stall: 1'b0, nrd: 0, rd: 32'h0, exp_wr: 0, exp_nack: 1'b1};
    tv[4]  = '{cmd: CmdWrWnoStop, addr: 7'h50, len: 8'd8, nwr: 5, wr: 48'h0088_776655FE,
               use_last: 1'b1, stall: 1'b0, nrd: 0, rd: 32'h0, exp_wr: 5, exp_nack: 1'b0};
    tv[5]  = '{cmd: CmdCompleteWr, addr: 7'h50, len: 8'd1, nwr: 1, wr: 48'hFE,
               use_last: 1'b0, stall: 1'b0, nrd: 0, rd: 32'h0, exp_wr: 1, exp_nack: 1'b0};
    tv[6]  = '{cmd: CmdRdWnoStop, addr: 7'h50, len: 8'd4, nwr: 0, wr: 48'h0,
               use_last: 1'b0, stall: 1'b1, nrd: 4, rd: 32'h88776655, exp_wr: 0, exp_nack: 1'b0};
    tv[7]  = '{cmd: CmdSetIdle, addr: 7'h50, len: 8'd0, nwr: 0, wr: 48'h0,
               use_last: 1'b0, stall: 1'b0, nrd: 0, rd: 32'h0, exp_wr: 0, exp_nack: 1'b0};
    tv[8]  = '{cmd: CmdCompleteRd, addr: 7'h50, len: 8'd2, nwr: 0, wr: 48'h0,
               use_last: 1'b0, stall: 1'b0, nrd: 2, rd: 32'h00008877, exp_wr: 0, exp_nack: 1'b0};
    // wr_last on beat 0: pointer moves to FF, mem[FF] keeps 66.
    tv[9]  = '{cmd: CmdCompleteWr, addr: 7'h50, len: 8'd8, nwr: 1, wr: 48'hFF,
               use_last: 1'b1, stall: 1'b0, nrd: 0, rd: 32'h0, exp_wr: 1, exp_nack: 1'b0};
    // burst_len 0 reads one beat; the dummy write byte is sunk.
    tv[10] = '{cmd: CmdCompleteRd, addr: 7'h50, len: 8'd0, nwr: 1, wr: 48'h5A,
               use_last: 1'b1, stall: 1'b0, nrd: 1, rd: 32'h66, exp_wr: 1, exp_nack: 1'b0};

    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("por");
    @(negedge clock);
    rst = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) run_txn(i);

    // Read latency, busy-time command rejection, then reset mid-burst.
    run_txn(5);
    cmd_vld = 1'b1;
    cmd = CmdCompleteRd;
    addr = 7'h50;
    burst_len = 8'd8;
    rd_ready = 1'b1;
    chk("lat_cmd_ready_pre", 32'(cmd_ready), 32'd1);
    @(posedge clock); #1;
    cmd = CmdCompleteWr;  // still valid, must be ignored while busy
    chk("lat_c1_rd_vld", 32'(rd_vld), 32'd0);
    chk("busy_c1_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clock); #1;
    chk("lat_c2_rd_vld", 32'(rd_vld), 32'd0);
    chk("busy_c2_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clock); #1;
    chk("lat_c3_rd_vld", 32'(rd_vld), 32'd1);
    chk("lat_c3_rd_data", 32'(rd_data), 32'h55);
    chk("busy_c3_cmd_ready", 32'(cmd_ready), 32'd0);
    cmd_vld = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("mid_rd_vld", 32'(rd_vld), 32'd1);
    chk("mid_rd_data", 32'(rd_data), 32'h66);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clock);
    rst = 1'b0;
    @(posedge clock); #1;
    chk_reset_outputs("post_rst");

    for (int i = 8; i < 11; i++) run_txn(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
